// File: rtl/rx_pkt_gen_tdpram_1clk.sv
// rtl/rx_pkt_gen_tdpram_1clk.sv - single-clock true dual-port packet buffer RAM
// Byte-enabled writes, 1/2-cycle read latency, per-port write modes, same-address collision handling.
module rx_pkt_gen_tdpram_1clk #(
  parameter int ADDR_DEPTH    = 2048,
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 256,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int RD_LATENCY    = 2,
  parameter int WR_MODE_A     = 0,
  parameter int WR_MODE_B     = 0,
  parameter int COLL_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [BE_WIDTH-1:0]   be_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  dout_valid_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [BE_WIDTH-1:0]   be_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dout_valid_b,
  output logic                  addr_err,
  output logic                  coll_ww,
  output logic                  coll_rw,
  input  logic                  coll_clr,
  output logic [15:0]           coll_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  logic                  ok_a, ok_b, same, ww, rw;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;
  logic [DATA_WIDTH:0]   res_a, res_b;
  logic                  s1_v_a, s1_v_b, fin_v_a, fin_v_b;
  logic [DATA_WIDTH-1:0] s1_d_a, s1_d_b, fin_d_a, fin_d_b;

  // Result of one access as {valid, data}; NO_CHANGE writes produce no result at all.
  function automatic logic [DATA_WIDTH:0] port_result(
    input logic en, input logic ok, input logic we,
    input logic [DATA_WIDTH-1:0] old_w, input logic [DATA_WIDTH-1:0] new_w, input int mode);
    port_result = '0;
    if (en) begin
      if (we && mode == 2)      port_result = '0;
      else if (!ok)             port_result = {1'b1, {DATA_WIDTH{1'b0}}};
      else if (we && mode == 1) port_result = {1'b1, new_w};
      else                      port_result = {1'b1, old_w};
    end
  endfunction

  always_comb begin
    ok_a  = en_a && ({1'b0, addr_a} < DEPTH);
    ok_b  = en_b && ({1'b0, addr_b} < DEPTH);
    same  = ok_a && ok_b && (addr_a == addr_b);
    ww    = same && we_a && we_b;
    rw    = same && (we_a != we_b);
    old_a = ok_a ? mem[addr_a] : '0;
    old_b = ok_b ? mem[addr_b] : '0;
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be_a[i]) new_a[8*i +: 8] = din_a[8*i +: 8];
      if (be_b[i]) new_b[8*i +: 8] = din_b[8*i +: 8];
      // Both ports write the same word: lane owned by the sole enabler, else by the priority port.
      if (ww) begin
        if (be_b[i] && (!be_a[i] || COLL_PRIORITY == 1)) new_a[8*i +: 8] = din_b[8*i +: 8];
        new_b[8*i +: 8] = new_a[8*i +: 8];
      end
    end
    res_a   = port_result(en_a, ok_a, we_a, old_a, new_a, WR_MODE_A);
    res_b   = port_result(en_b, ok_b, we_b, old_b, new_b, WR_MODE_B);
    fin_v_a = (RD_LATENCY == 1) ? res_a[DATA_WIDTH]     : s1_v_a;
    fin_d_a = (RD_LATENCY == 1) ? res_a[DATA_WIDTH-1:0] : s1_d_a;
    fin_v_b = (RD_LATENCY == 1) ? res_b[DATA_WIDTH]     : s1_v_b;
    fin_d_b = (RD_LATENCY == 1) ? res_b[DATA_WIDTH-1:0] : s1_d_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ok_a && we_a) mem[addr_a] <= new_a;
      if (ok_b && we_b) mem[addr_b] <= new_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_a       <= 1'b0;
      s1_v_b       <= 1'b0;
      s1_d_a       <= '0;
      s1_d_b       <= '0;
      dout_a       <= '0;
      dout_b       <= '0;
      dout_valid_a <= 1'b0;
      dout_valid_b <= 1'b0;
      addr_err     <= 1'b0;
      coll_ww      <= 1'b0;
      coll_rw      <= 1'b0;
      coll_cnt     <= '0;
    end else begin
      s1_v_a       <= res_a[DATA_WIDTH];
      s1_d_a       <= res_a[DATA_WIDTH-1:0];
      s1_v_b       <= res_b[DATA_WIDTH];
      s1_d_b       <= res_b[DATA_WIDTH-1:0];
      dout_valid_a <= fin_v_a;
      dout_valid_b <= fin_v_b;
      if (fin_v_a) dout_a <= fin_d_a;
      if (fin_v_b) dout_b <= fin_d_b;
      addr_err     <= (en_a && !ok_a) || (en_b && !ok_b);
      coll_ww      <= ww;
      coll_rw      <= rw;
      if (coll_clr)                            coll_cnt <= '0;
      else if ((ww || rw) && coll_cnt != '1)   coll_cnt <= coll_cnt + 16'd1;
    end
  end

`ifdef RX_PKT_GEN_COLL_WARN
  always_ff @(posedge clk) begin
    if (!reset && (ww || rw)) $display("warning: %s collision at address %0d", ww ? "write/write" : "read/write", addr_a);
  end
`endif

endmodule
